dif_pair_serializer: RTL

//  Receiving end of a DIF butterfly's parallel output: accepts {L,R} complex pairs (no backpressure)
//  and emits one block of FFT_LEN serial complex samples: L pairs in arrival order, then R pairs.

---
 rtl/dif_pair_serializer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/dif_pair_serializer.sv
// dif_pair_serializer
// Collects {L,R} complex pairs from a DIF butterfly into a ping-pong pair of
// banks and streams each completed block out serially over valid/ready:
// all L samples of the block in arrival order, then all R samples.
// The input side has no backpressure; pairs arriving while the target bank
// is still waiting to be drained are dropped and flagged on o_ovf_strb.

module dif_pair_serializer #(
    parameter int IN_W    = 10,
    parameter int FFT_LEN = 256
) (
    input  logic                   mclk,
    input  logic                   i_init_n,
    input  logic                   i_vld,
    input  logic signed [IN_W-1:0] i_LI,
    input  logic signed [IN_W-1:0] i_LQ,
    input  logic signed [IN_W-1:0] i_RI,
    input  logic signed [IN_W-1:0] i_RQ,
    output logic                   o_vld,
    input  logic                   i_rdy,
    output logic signed [IN_W-1:0] o_I,
    output logic signed [IN_W-1:0] o_Q,
    output logic                   o_last,
    output logic                   o_ovf_strb
);

    localparam int HALF = FFT_LEN / 2;
    localparam int RAW  = $clog2(FFT_LEN);
    localparam int WAW  = (FFT_LEN > 2) ? RAW - 1 : 1;
    localparam int DW   = 2 * IN_W;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } rd_state_t;

    // Storage: [bank][pair index], each word packed as {I, Q}
    logic [DW-1:0] lmem [2][HALF];
    logic [DW-1:0] rmem [2][HALF];

    // Write side
    logic           wr_bank;
    logic [WAW-1:0] wr_cnt;
    logic [1:0]     full;
    logic [1:0]     full_nxt;
    logic           wr_acc;
    logic           wr_drop;
    logic           wr_end;

    // Read side. iss_bank is the bank reads are being issued from; rd_bank is
    // the oldest bank whose samples have not all left the output port yet.
    // They differ while the tail of one block is still in the output pipe and
    // the next block's reads have already started, which keeps o_vld
    // continuous from block to block.
    rd_state_t      state;
    logic           iss_bank;
    logic           rd_bank;
    logic [RAW-1:0] rd_cnt;
    logic [RAW-1:0] rd_off;
    logic [WAW-1:0] rd_idx;
    logic           rd_is_r;
    logic [1:0]     pend;       // banks fully issued but not yet fully transferred
    logic [1:0]     pend_nxt;
    logic           issue;
    logic           iss_end;

    // RAM read register (one entry) and output skid (out regs + sk_*)
    logic [DW-1:0]  rq_data;
    logic           rq_vld;
    logic           rq_last;
    logic [DW-1:0]  sk_data;
    logic           sk_vld;
    logic           sk_last;
    logic           push;
    logic           pop;
    logic           retire;
    logic           out_load;

    assign wr_acc  = i_vld & ~full[wr_bank];
    assign wr_drop = i_vld &  full[wr_bank];
    assign wr_end  = wr_acc && (wr_cnt == WAW'(HALF - 1));

    assign rd_off  = rd_cnt & RAW'(HALF - 1);
    assign rd_idx  = rd_off[WAW-1:0];
    assign rd_is_r = (rd_cnt >= RAW'(HALF));

    // A read is issued only when the read register is empty or is certain to
    // move into the skid this cycle; i_rdy never reaches the RAM address.
    assign issue    = (state == DRAIN) && (~rq_vld || ~sk_vld);
    assign iss_end  = issue && (rd_cnt == RAW'(FFT_LEN - 1));
    assign push     = rq_vld & ~sk_vld;
    assign pop      = o_vld & i_rdy;
    assign retire   = pop & o_last;
    assign out_load = ~o_vld | pop;

    // Full flags: set by the last pair of a block, cleared when its last sample leaves
    always_comb begin
        full_nxt = full;
        if (wr_end) full_nxt[wr_bank] = 1'b1;
        if (retire) full_nxt[rd_bank] = 1'b0;
    end

    // Count of banks issued but still in flight towards the output
    always_comb begin
        pend_nxt = pend;
        case ({iss_end, retire})
            2'b10:   pend_nxt = pend + 2'd1;
            2'b01:   pend_nxt = pend - 2'd1;
            default: pend_nxt = pend;
        endcase
    end

    // Write-side control: pair counter, bank toggle, full flags, drop strobe
    always_ff @(posedge mclk or negedge i_init_n) begin
        if (!i_init_n) begin
            wr_bank    <= 1'b0;
            wr_cnt     <= '0;
            full       <= '0;
            o_ovf_strb <= 1'b0;
        end else begin
            full       <= full_nxt;
            o_ovf_strb <= wr_drop;
            if (wr_acc) begin
                if (wr_end) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt  <= wr_cnt + WAW'(1);
                end
            end
        end
    end

    // RAM write ports, one per array
    always_ff @(posedge mclk) begin
        if (wr_acc) begin
            lmem[wr_bank][wr_cnt] <= {i_LI, i_LQ};
            rmem[wr_bank][wr_cnt] <= {i_RI, i_RQ};
        end
    end

    // Synchronous RAM read: L half first, then R half of the issuing bank
    always_ff @(posedge mclk) begin
        if (issue) begin
            rq_data <= rd_is_r ? rmem[iss_bank][rd_idx] : lmem[iss_bank][rd_idx];
        end
    end

    // Read FSM: issue addresses for a full bank, chaining straight into the
    // other bank when it is already full and nothing else is in flight
    always_ff @(posedge mclk or negedge i_init_n) begin
        if (!i_init_n) begin
            state    <= IDLE;
            iss_bank <= 1'b0;
            rd_bank  <= 1'b0;
            rd_cnt   <= '0;
            pend     <= '0;
            rq_vld   <= 1'b0;
            rq_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // pend==2 means full[iss_bank] still belongs to a block
                    // whose samples are draining; it is not a new block
                    if (full[iss_bank] && (pend != 2'd2)) begin
                        state  <= DRAIN;
                        rd_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        if (iss_end) begin
                            iss_bank <= ~iss_bank;
                            rd_cnt   <= '0;
                            if (!(full[~iss_bank] && (pend == 2'd0))) state <= IDLE;
                        end else begin
                            rd_cnt <= rd_cnt + RAW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            pend <= pend_nxt;
            if (retire) rd_bank <= ~rd_bank;

            if (issue) begin
                rq_vld  <= 1'b1;
                rq_last <= (rd_cnt == RAW'(FFT_LEN - 1));
            end else if (push) begin
                rq_vld  <= 1'b0;
            end
        end
    end

    // Two-entry output skid: output regs hold steady under stall, sk_* catches
    // the read register when the output is occupied and not popping
    always_ff @(posedge mclk or negedge i_init_n) begin
        if (!i_init_n) begin
            o_vld   <= 1'b0;
            o_last  <= 1'b0;
            o_I     <= '0;
            o_Q     <= '0;
            sk_vld  <= 1'b0;
            sk_last <= 1'b0;
            sk_data <= '0;
        end else begin
            if (out_load) begin
                if (sk_vld) begin
                    o_vld  <= 1'b1;
                    o_last <= sk_last;
                    o_I    <= sk_data[DW-1:IN_W];
                    o_Q    <= sk_data[IN_W-1:0];
                    sk_vld <= 1'b0;
                end else if (push) begin
                    o_vld  <= 1'b1;
                    o_last <= rq_last;
                    o_I    <= rq_data[DW-1:IN_W];
                    o_Q    <= rq_data[IN_W-1:0];
                end else begin
                    o_vld  <= 1'b0;
                    o_last <= 1'b0;
                end
            end else if (push) begin
                sk_vld  <= 1'b1;
                sk_last <= rq_last;
                sk_data <= rq_data;
            end
        end
    end

endmodule
